// File: rtl/router_pkg.sv
// Shared router definitions: data/depth defaults, header field layout and
// the tagged word stored in each per-destination FIFO.
package router_pkg;

  localparam int ROUTER_DATA_W     = 8;
  localparam int ROUTER_FIFO_DEPTH = 16;

  // Header byte layout: length in [7:2], destination address in [1:0].
  localparam int HDR_LEN_MSB  = 7;
  localparam int HDR_LEN_LSB  = 2;
  localparam int HDR_ADDR_MSB = 1;
  localparam int HDR_ADDR_LSB = 0;

  typedef struct packed {
    logic [HDR_LEN_MSB-HDR_LEN_LSB:0]   len;
    logic [HDR_ADDR_MSB-HDR_ADDR_LSB:0] addr;
  } hdr_t;

  typedef struct packed {
    logic                     hdr;
    logic [ROUTER_DATA_W-1:0] data;
  } fifo_word_t;

endpackage

// File: rtl/router_fifo_ptr.sv
// FIFO pointer with wrap bit: low AW bits index the array, MSB toggles on
// every rollover so full and empty can be told apart.
module router_fifo_ptr #(
  parameter int AW = 4
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        clear,
  input  logic        inc,
  output logic [AW:0] ptr
);

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      ptr <= '0;
    end else if (clear) begin
      ptr <= '0;
    end else if (inc) begin
      ptr <= ptr + 1'b1;
    end
  end

endmodule

// File: rtl/router_fifo.sv
// Per-destination packet buffer of the 1x3 router: stores header-tagged
// bytes and tracks the remaining bytes of the packet being drained.
module router_fifo
  import router_pkg::*;
#(
  parameter int DEPTH = ROUTER_FIFO_DEPTH,
  parameter int WIDTH = ROUTER_DATA_W
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             soft_reset,
  input  logic             write_enb,
  input  logic             read_enb,
  input  logic             lfd_state,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]    wr_ptr;
  logic [AW:0]    rd_ptr;
  logic [WIDTH:0] mem [DEPTH];
  logic [WIDTH:0] rd_word;
  logic [6:0]     pkt_cnt;
  logic           wr_acc;
  logic           rd_acc;

  assign empty  = (wr_ptr == rd_ptr);
  assign full   = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign wr_acc = write_enb && !full && !soft_reset;
  assign rd_acc = read_enb && !empty && !soft_reset;
  assign rd_word = mem[rd_ptr[AW-1:0]];

  router_fifo_ptr #(.AW(AW)) u_wr_ptr (
    .clock  (clock),
    .resetn (resetn),
    .clear  (soft_reset),
    .inc    (wr_acc),
    .ptr    (wr_ptr)
  );

  router_fifo_ptr #(.AW(AW)) u_rd_ptr (
    .clock  (clock),
    .resetn (resetn),
    .clear  (soft_reset),
    .inc    (rd_acc),
    .ptr    (rd_ptr)
  );

  // Storage is deliberately left out of both resets; the pointers define validity.
  always_ff @(posedge clock) begin
    if (wr_acc) begin
      mem[wr_ptr[AW-1:0]] <= {lfd_state, data_in};
    end
  end

  // A header reloads the counter with payload length plus parity; data_out
  // returns to zero only once the packet has been fully drained.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      data_out <= '0;
      pkt_cnt  <= '0;
    end else if (soft_reset) begin
      data_out <= '0;
      pkt_cnt  <= '0;
    end else if (rd_acc) begin
      data_out <= rd_word[WIDTH-1:0];
      if (rd_word[WIDTH]) begin
        pkt_cnt <= 7'(rd_word[HDR_LEN_MSB:HDR_LEN_LSB]) + 7'd1;
      end else if (pkt_cnt != 7'd0) begin
        pkt_cnt <= pkt_cnt - 7'd1;
      end
    end else if (pkt_cnt == 7'd0) begin
      data_out <= '0;
    end
  end

endmodule

// File: tb/tb_router_fifo.sv
// Self-checking bench for router_fifo: directed scenarios plus a randomized
// run, all compared against a queue-based packet-buffer model.
module tb_router_fifo;

  localparam int DEPTH = 16;

  logic       clock = 1'b0;
  logic       resetn = 1'b0;
  logic       soft_reset = 1'b0;
  logic       write_enb = 1'b0;
  logic       read_enb = 1'b0;
  logic       lfd_state = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic [7:0] data_out;
  logic       full;
  logic       empty;

  int vectors = 0;
  int miscompares = 0;

  logic [8:0] mq[$];
  int         mcnt = 0;
  logic [7:0] mdout = 8'h00;

  router_fifo #(.DEPTH(DEPTH), .WIDTH(8)) dut (
    .clock      (clock),
    .resetn     (resetn),
    .soft_reset (soft_reset),
    .write_enb  (write_enb),
    .read_enb   (read_enb),
    .lfd_state  (lfd_state),
    .data_in    (data_in),
    .data_out   (data_out),
    .full       (full),
    .empty      (empty)
  );

  always #5 clock = ~clock;

  task automatic model_reset();
    mq.delete();
    mcnt  = 0;
    mdout = 8'h00;
  endtask

  // Advance one rising edge, update the model from the inputs seen at that
  // edge, and return 1 time unit later so outputs are settled.
  task automatic tick();
    logic [8:0] w;
    bit rd;
    bit wr;
    @(posedge clock);
    if (soft_reset) begin
      model_reset();
    end else begin
      rd = read_enb && (mq.size() != 0);
      wr = write_enb && (mq.size() < DEPTH);
      if (rd) begin
        w = mq.pop_front();
        mdout = w[7:0];
        if (w[8]) mcnt = int'(w[7:2]) + 1;
        else if (mcnt > 0) mcnt = mcnt - 1;
      end else if (mcnt == 0) begin
        mdout = 8'h00;
      end
      if (wr) mq.push_back({lfd_state, data_in});
    end
    #1;
  endtask

  task automatic idle_inputs();
    write_enb  = 1'b0;
    read_enb   = 1'b0;
    lfd_state  = 1'b0;
    soft_reset = 1'b0;
    data_in    = 8'h00;
  endtask

  task automatic flush();
    idle_inputs();
    soft_reset = 1'b1;
    tick();
    soft_reset = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    vectors++;
    if (empty !== 1'b1) begin miscompares++; $display("[TB] FAIL reset_empty: got %b expected 1", empty); end
    vectors++;
    if (full !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_full: got %b expected 0", full); end
    vectors++;
    if (data_out !== 8'h00) begin miscompares++; $display("[TB] FAIL reset_data_out: got %h expected 00", data_out); end
    #5 resetn = 1'b1;
    model_reset();
  endtask

  task automatic test_basic();
    logic [7:0] exp_bytes [3];
    exp_bytes[0] = 8'h0D; exp_bytes[1] = 8'hAA; exp_bytes[2] = 8'hBB;
    write_enb = 1'b1; lfd_state = 1'b1; data_in = exp_bytes[0];
    tick();
    vectors++;
    if (empty !== 1'b0) begin miscompares++; $display("[TB] FAIL basic_empty_fall: got %b expected 0", empty); end
    lfd_state = 1'b0;
    for (int i = 1; i < 3; i++) begin
      data_in = exp_bytes[i];
      tick();
      vectors++;
      if (full !== 1'b0) begin miscompares++; $display("[TB] FAIL basic_full: got %b expected 0", full); end
    end
    write_enb = 1'b0; read_enb = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      vectors++;
      if (data_out !== exp_bytes[i]) begin miscompares++; $display("[TB] FAIL basic_read%0d: got %h expected %h", i, data_out, exp_bytes[i]); end
    end
    read_enb = 1'b0;
    vectors++;
    if (empty !== 1'b1) begin miscompares++; $display("[TB] FAIL basic_empty_after: got %b expected 1", empty); end
  endtask

  task automatic test_pkt_cnt();
    logic [7:0] pkt [5];
    pkt[0] = 8'h0D; pkt[1] = 8'h21; pkt[2] = 8'h42; pkt[3] = 8'h63; pkt[4] = 8'h5A;
    flush();
    write_enb = 1'b1;
    for (int i = 0; i < 5; i++) begin
      lfd_state = (i == 0);
      data_in = pkt[i];
      tick();
    end
    write_enb = 1'b0; lfd_state = 1'b0; read_enb = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      vectors++;
      if (dut.pkt_cnt !== 7'(4 - i)) begin miscompares++; $display("[TB] FAIL pkt_cnt_step%0d: got %0d expected %0d", i, dut.pkt_cnt, 4 - i); end
      vectors++;
      if (data_out !== pkt[i]) begin miscompares++; $display("[TB] FAIL pkt_data%0d: got %h expected %h", i, data_out, pkt[i]); end
    end
    read_enb = 1'b0;
    tick();
    vectors++;
    if (data_out !== 8'h00) begin miscompares++; $display("[TB] FAIL pkt_idle_zero: got %h expected 00", data_out); end
  endtask

  task automatic fill_random(output logic [7:0] arr [DEPTH]);
    write_enb = 1'b1; lfd_state = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      arr[i] = 8'($urandom);
      if (arr[i] == 8'h55) arr[i] = 8'h54;
      data_in = arr[i];
      tick();
    end
    write_enb = 1'b0;
  endtask

  task automatic test_fill();
    logic [7:0] arr [DEPTH];
    flush();
    fill_random(arr);
    vectors++;
    if (full !== 1'b1) begin miscompares++; $display("[TB] FAIL fill_full: got %b expected 1", full); end
    write_enb = 1'b1; data_in = 8'h55;
    tick();
    write_enb = 1'b0;
    vectors++;
    if (full !== 1'b1) begin miscompares++; $display("[TB] FAIL fill_overflow_full: got %b expected 1", full); end
    read_enb = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      tick();
      vectors++;
      if (data_out !== arr[i]) begin miscompares++; $display("[TB] FAIL fill_read%0d: got %h expected %h", i, data_out, arr[i]); end
    end
    read_enb = 1'b0;
    vectors++;
    if (empty !== 1'b1) begin miscompares++; $display("[TB] FAIL fill_drained: got %b expected 1", empty); end
  endtask

  task automatic test_simultaneous();
    logic [7:0] arr [DEPTH];
    flush();
    fill_random(arr);
    read_enb = 1'b1; write_enb = 1'b1; data_in = 8'h77;
    tick();
    vectors++;
    if (full !== 1'b0) begin miscompares++; $display("[TB] FAIL simul_full_drop: got %b expected 0", full); end
    vectors++;
    if (data_out !== arr[0]) begin miscompares++; $display("[TB] FAIL simul_full_read: got %h expected %h", data_out, arr[0]); end
    write_enb = 1'b0;
    for (int i = 1; i < DEPTH - 1; i++) begin
      tick();
      vectors++;
      if (data_out !== mdout) begin miscompares++; $display("[TB] FAIL simul_drain%0d: got %h expected %h", i, data_out, mdout); end
    end
    write_enb = 1'b1; data_in = 8'h99;
    tick();
    vectors++;
    if (data_out !== arr[DEPTH-1]) begin miscompares++; $display("[TB] FAIL simul_one_read: got %h expected %h", data_out, arr[DEPTH-1]); end
    vectors++;
    if (empty !== 1'b0) begin miscompares++; $display("[TB] FAIL simul_one_count: got empty=%b expected 0", empty); end
    write_enb = 1'b0;
    tick();
    read_enb = 1'b0;
    vectors++;
    if (data_out !== 8'h99) begin miscompares++; $display("[TB] FAIL simul_one_written: got %h expected 99", data_out); end
    vectors++;
    if (empty !== 1'b1) begin miscompares++; $display("[TB] FAIL simul_final_empty: got %b expected 1", empty); end
  endtask

  task automatic test_wrap();
    flush();
    for (int i = 0; i < 10; i++) begin
      write_enb = 1'b1; data_in = 8'($urandom); tick();
    end
    write_enb = 1'b0; read_enb = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    read_enb = 1'b0; write_enb = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      data_in = 8'($urandom); tick();
    end
    write_enb = 1'b0;
    vectors++;
    if (full !== 1'b1) begin miscompares++; $display("[TB] FAIL wrap_full: got %b expected 1", full); end
    vectors++;
    if (dut.wr_ptr[4] !== 1'(((10 + DEPTH) / DEPTH) % 2)) begin miscompares++; $display("[TB] FAIL wrap_bit: got %b expected 1", dut.wr_ptr[4]); end
    read_enb = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      tick();
      vectors++;
      if (data_out !== mdout) begin miscompares++; $display("[TB] FAIL wrap_read%0d: got %h expected %h", i, data_out, mdout); end
    end
    read_enb = 1'b0;
  endtask

  task automatic test_flush();
    flush();
    write_enb = 1'b1; lfd_state = 1'b1; data_in = 8'h14;
    tick();
    lfd_state = 1'b0;
    for (int i = 0; i < 4; i++) begin
      data_in = 8'h30 + 8'(i); tick();
    end
    write_enb = 1'b0; read_enb = 1'b1;
    tick();
    soft_reset = 1'b1;
    tick();
    soft_reset = 1'b0; read_enb = 1'b0;
    vectors++;
    if (empty !== 1'b1) begin miscompares++; $display("[TB] FAIL flush_empty: got %b expected 1", empty); end
    vectors++;
    if (data_out !== 8'h00) begin miscompares++; $display("[TB] FAIL flush_data_out: got %h expected 00", data_out); end
    write_enb = 1'b1; data_in = 8'h3C;
    tick();
    write_enb = 1'b0; read_enb = 1'b1;
    tick();
    read_enb = 1'b0;
    vectors++;
    if (data_out !== 8'h3C) begin miscompares++; $display("[TB] FAIL flush_restart: got %h expected 3C", data_out); end
  endtask

  task automatic test_async_reset();
    flush();
    write_enb = 1'b1; lfd_state = 1'b1; data_in = 8'h0D;
    tick();
    write_enb = 1'b0; lfd_state = 1'b0; read_enb = 1'b1;
    tick();
    read_enb = 1'b0;
    write_enb = 1'b1; data_in = 8'h11;
    vectors++;
    if (data_out !== 8'h0D) begin miscompares++; $display("[TB] FAIL areset_pre: got %h expected 0D", data_out); end
    #2 resetn = 1'b0;
    #1;
    model_reset();
    vectors++;
    if (data_out !== 8'h00) begin miscompares++; $display("[TB] FAIL areset_data_out: got %h expected 00", data_out); end
    vectors++;
    if (empty !== 1'b1) begin miscompares++; $display("[TB] FAIL areset_empty: got %b expected 1", empty); end
    vectors++;
    if (full !== 1'b0) begin miscompares++; $display("[TB] FAIL areset_full: got %b expected 0", full); end
    #2 resetn = 1'b1;
    idle_inputs();
  endtask

  task automatic test_random();
    flush();
    for (int i = 0; i < 400; i++) begin
      write_enb  = (i < 200) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      read_enb   = (i < 200) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      lfd_state  = ($urandom_range(0, 7) == 0);
      soft_reset = ($urandom_range(0, 99) == 0);
      data_in    = 8'($urandom);
      tick();
      vectors++;
      if (data_out !== mdout) begin miscompares++; $display("[TB] FAIL rand_data_out@%0d: got %h expected %h", i, data_out, mdout); end
      vectors++;
      if (empty !== (mq.size() == 0)) begin miscompares++; $display("[TB] FAIL rand_empty@%0d: got %b expected %b", i, empty, mq.size() == 0); end
      vectors++;
      if (full !== (mq.size() == DEPTH)) begin miscompares++; $display("[TB] FAIL rand_full@%0d: got %b expected %b", i, full, mq.size() == DEPTH); end
      vectors++;
      if (dut.pkt_cnt !== 7'(mcnt)) begin miscompares++; $display("[TB] FAIL rand_pkt_cnt@%0d: got %0d expected %0d", i, dut.pkt_cnt, mcnt); end
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_pkt_cnt();
    test_fill();
    test_simultaneous();
    test_wrap();
    test_flush();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/router_fifo.md
# router_fifo

Per-destination packet buffer of the 1x3 router. Three instances sit directly downstream of the synchroniser: each accepts bytes when its one-hot `write_enb` bit is set, holds up to `DEPTH` bytes tagged with a header marker, and presents them to its output port on `read_enb`. It reports `full`/`empty` back to the synchroniser, which derives `fifo_full`, `vld_out_N` and the soft-reset timeout. It also flushes itself when that timeout fires.

## Interface
- `DEPTH`, 16, number of entries; power of two, ≥ 4.
- `WIDTH`, 8, data byte width; stored word is `WIDTH+1` bits (bit `WIDTH` = header marker).
- `clock`  in  1  single clock; all state on rising edge.
- `resetn`  in  1  reset, asynchronous and active-low.
- `soft_reset`  in  1  synchronous flush from the synchroniser timeout; active-high.
- `write_enb`  in  1  this FIFO's bit of the synchroniser's `write_enb[2:0]`.
- `read_enb`  in  1  read request from the output port.
- `lfd_state`  in  1  high while `data_in` is a packet header byte.
- `data_in`  in  WIDTH  byte from the router register stage.
- `data_out`  out  WIDTH  registered read data.
- `full`  out  1  no free entry.
- `empty`  out  1  no stored entry.

## Operation
- Storage: `DEPTH` x (`WIDTH`+1) array. Write word = {`lfd_state`, `data_in`}.
- Pointers: `wr_ptr` and `rd_ptr`, each log2(`DEPTH`)+1 bits; index = low bits, MSB = wrap flag.
- `empty` = pointers equal. `full` = index bits equal and wrap bits differ. Both are decoded combinationally from registered pointers.
- Write accepted iff `write_enb` && !`full`. Write while full is dropped; pointer and contents are unchanged.
- Read accepted iff `read_enb` && !`empty`. `data_out` <= stored byte; `rd_ptr` increments.
- Packet counter `pkt_cnt`, 7 bits:
  - On an accepted read of a word with the header marker set: `pkt_cnt` <= byte[7:2] + 1 (payload length plus parity).
  - On an accepted read of a non-header word with `pkt_cnt` > 0: `pkt_cnt` decrements.
  - `pkt_cnt` never decrements below 0.
- Idle output: if no read is accepted in a cycle and `pkt_cnt` == 0, `data_out` <= 0. Otherwise `data_out` holds its value.
- Simultaneous read and write: both are accepted if their individual conditions hold. `full` and `empty` are evaluated before the update, so:
  - when full, only the read proceeds;
  - when empty, only the write proceeds.
- `soft_reset` has priority over read and write in the same cycle. It sets `wr_ptr`, `rd_ptr`, `pkt_cnt` and `data_out` to 0. Memory contents are not cleared.
- `resetn` low, asynchronously: pointers 0, `pkt_cnt` 0, `data_out` 0. Consequently `empty`=1 and `full`=0 during and after reset. Reset mid-packet discards the packet.

## Timing
- Write-to-`empty` deassert: 1 cycle. Word written at edge N gives `empty`=0 after edge N.
- Read latency: 1 cycle. `read_enb` sampled at edge N gives `data_out` valid after edge N.
- `full` asserts after the edge that stores the `DEPTH`-th word. It deasserts after the first accepted read.
- Pointer wrap: the index rolls from `DEPTH`-1 to 0 and the wrap bit toggles. No bubble at the rollover.
- `soft_reset` takes effect at the next edge; outputs show the flushed state in the cycle after it.
- No combinational path from inputs to outputs.

## Structure
- Shared package `router_pkg`:
  - `ROUTER_DATA_W` (8), `ROUTER_FIFO_DEPTH` (16);
  - header field positions: address [1:0], length [7:2];
  - a typedef for the tagged FIFO word.
- One natural sub-module: `router_fifo_ptr`, a pointer register with wrap bit and increment enable, instantiated twice.
- Storage is an inferred register array; no vendor macro.

## Test plan
- Reset, then write 3 bytes {hdr 0x0D (len 3, addr 1), 0xAA, 0xBB} with `lfd_state` on the first: `empty` falls after the first write and `full` stays 0. Read 3: `data_out` = 0x0D, 0xAA, 0xBB on consecutive cycles, then `empty`=1.
- Packet counter: header 0x0D, 3 payload bytes, 1 parity byte, read continuously:
  - `pkt_cnt` = 4 after the header, 0 after the parity read;
  - `data_out` = 0 in the first idle cycle afterwards.
- Fill 16 words: `full`=1 after the 16th. A 17th write (0x55) is dropped. Read all 16: original order is preserved and 0x55 never appears.
- With the FIFO full, assert `read_enb` and `write_enb` together for one cycle: the read is accepted, the write is dropped, and `full` drops to 0. Repeat at 1 entry: both are accepted and the count stays 1.
- Wrap: 10 writes, 10 reads, then 16 writes. `full`=1 with `wr_ptr` wrapped, and data reads back in order.
- Flush and reset:
  - `soft_reset` pulse with 5 words stored and a read in the same cycle: `empty`=1 and `data_out`=0 next cycle; the read is not performed.
  - `resetn` low mid-write: `data_out`=0 and `empty`=1 immediately, without waiting for a clock edge.
